pulse_histogram: RTL and testbench

Multichannel-analyser stage downstream of the pulse-height detector. Bins every captured pulse height into a 2^CH_BITS-channel spectrum held in on-chip RAM. Accumulates counts with a pipelined read-modify-write and gives the host an independent readout port and a full-memory clear sweep. Sits between the pulse-height detector and the host/display interface, in the 65 MHz ADC clock domain.

---
 rtl/mca_pkg.sv | 15 +
 rtl/pulse_histogram_hist_ram.sv | 32 +++
 rtl/pulse_histogram.sv | 116 +++++++++++
 tb/tb_pulse_histogram.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mca_pkg.sv
// Shared types and helpers for the multichannel-analyser histogram path.
package mca_pkg;
  localparam int ADC_BITS    = 14;
  localparam int CH_BITS_DEF = 10;
  localparam int CNT_W_DEF   = 24;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  // Increment v, saturating at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max;
    max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max) ? max : v + 32'd1;
  endfunction
endpackage

// File: rtl/pulse_histogram_hist_ram.sv
// Spectrum RAM: write port plus two registered read ports (RMW and host),
// all read-before-write.
module hist_ram #(
  parameter int AW = 10,
  parameter int DW = 24
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [AW-1:0] ra_i,
  output logic [DW-1:0] rd_a_o,
  input  logic [AW-1:0] rb_i,
  output logic [DW-1:0] rd_b_o
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_o <= '0;
      rd_b_o <= '0;
    end else begin
      rd_a_o <= mem_q[ra_i];
      rd_b_o <= mem_q[rb_i];
    end
  end
endmodule

// File: rtl/pulse_histogram.sv
// Pulse-height histogram: edge detect, discriminators, 3-stage RMW into the
// spectrum RAM with write forwarding, clear sweep and event statistics.
module pulse_histogram
  import mca_pkg::*;
#(
  parameter int CH_BITS = CH_BITS_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter logic [ADC_BITS-1:0] LLD = 14'h1900,
  parameter logic [ADC_BITS-1:0] ULD = 14'h3FFF
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [ADC_BITS-1:0] ev_height_i,
  input  logic                ev_valid_i,
  input  logic                acq_en_i,
  input  logic                clr_req_i,
  input  logic [CH_BITS-1:0]  rd_addr_i,
  output logic [CNT_W-1:0]    rd_data_o,
  output logic                busy_o,
  output logic [31:0]         total_cnt_o,
  output logic [15:0]         drop_cnt_o
);
  localparam logic [CH_BITS-1:0] LAST_CH = '1;

  state_e             state_q;
  logic [CH_BITS-1:0] clr_addr_q;
  logic               ev_prev_q;
  logic [1:0]         vld_q;
  logic [CH_BITS-1:0] bin0_q, bin1_q;
  logic               wr_vld_q;
  logic [CH_BITS-1:0] wr_bin_q;
  logic [CNT_W-1:0]   wr_val_q;
  logic [31:0]        total_q;
  logic [15:0]        drop_q;

  logic               rise, in_win, accept, reject;
  logic [CNT_W-1:0]   ram_a, cur, nxt, wd;
  logic [CH_BITS-1:0] wa;
  logic               we;

  always_comb begin
    rise   = ev_valid_i & ~ev_prev_q;
    in_win = (ev_height_i >= LLD) && (ev_height_i <= ULD);
    accept = rise & (state_q == RUN) & ~clr_req_i & acq_en_i & in_win;
    reject = rise & ((state_q == CLEAR) | clr_req_i | (acq_en_i & ~in_win));
    // The RAM read of bin1 was sampled at the same edge as the previous write,
    // so a back-to-back hit on one channel must take the just-written value.
    cur = (wr_vld_q && (wr_bin_q == bin1_q)) ? wr_val_q : ram_a;
    nxt = CNT_W'(sat_inc(32'(cur), CNT_W));
    we  = 1'b0;
    wa  = clr_addr_q;
    wd  = '0;
    if (vld_q[1]) begin
      we = 1'b1;
      wa = bin1_q;
      wd = nxt;
    end else if ((state_q == CLEAR) && (vld_q == 2'b00)) begin
      we = 1'b1;
    end
  end

  hist_ram #(.AW(CH_BITS), .DW(CNT_W)) u_ram (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .we_i   (we),
    .wa_i   (wa),
    .wd_i   (wd),
    .ra_i   (bin0_q),
    .rd_a_o (ram_a),
    .rb_i   (rd_addr_i),
    .rd_b_o (rd_data_o)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      ev_prev_q  <= 1'b0;
      vld_q      <= '0;
      bin0_q     <= '0;
      bin1_q     <= '0;
      wr_vld_q   <= 1'b0;
      wr_bin_q   <= '0;
      wr_val_q   <= '0;
      total_q    <= '0;
      drop_q     <= '0;
    end else begin
      ev_prev_q <= ev_valid_i;
      vld_q     <= {vld_q[0], accept};
      bin0_q    <= ev_height_i[ADC_BITS-1 -: CH_BITS];
      bin1_q    <= bin0_q;
      wr_vld_q  <= vld_q[1];
      wr_bin_q  <= bin1_q;
      wr_val_q  <= nxt;

      if (clr_req_i) begin
        state_q    <= CLEAR;
        clr_addr_q <= '0;
      end else if ((state_q == CLEAR) && (vld_q == 2'b00)) begin
        // Sweep waits for in-flight writes so none lands behind it.
        clr_addr_q <= clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_CH) state_q <= RUN;
      end

      if (clr_req_i) total_q <= '0;
      else if (vld_q[1] && (state_q == RUN)) total_q <= sat_inc(total_q, 32);

      if (clr_req_i) drop_q <= {15'd0, reject};
      else if (reject) drop_q <= 16'(sat_inc(32'(drop_q), 16));
    end
  end

  assign busy_o      = (state_q == CLEAR);
  assign total_cnt_o = total_q;
  assign drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_pulse_histogram.sv
// Randomized bench for pulse_histogram; a 24-bit and a 4-bit counter instance
// share stimulus and are compared against a per-channel count model.
module tb_pulse_histogram;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] ev_height;
  logic        ev_valid, acq_en, clr_req;
  logic [9:0]  rd_addr;
  logic [23:0] rd0;
  logic [3:0]  rd1;
  logic        busy0, busy1;
  logic [31:0] tot0, tot1;
  logic [15:0] drp0, drp1;

  always #5 clk = ~clk;

  pulse_histogram u_d0 (
    .clk_i(clk), .rst_n(rst_n), .ev_height_i(ev_height), .ev_valid_i(ev_valid),
    .acq_en_i(acq_en), .clr_req_i(clr_req), .rd_addr_i(rd_addr), .rd_data_o(rd0),
    .busy_o(busy0), .total_cnt_o(tot0), .drop_cnt_o(drp0));

  pulse_histogram #(.CNT_W(4)) u_d1 (
    .clk_i(clk), .rst_n(rst_n), .ev_height_i(ev_height), .ev_valid_i(ev_valid),
    .acq_en_i(acq_en), .clr_req_i(clr_req), .rd_addr_i(rd_addr), .rd_data_o(rd1),
    .busy_o(busy1), .total_cnt_o(tot1), .drop_cnt_o(drp1));

  int chk = 0;
  int pass = 0;
  int model [1024];
  int tot_m, drp_m;
  bit m_clr;
  logic [23:0] scan0 [1024];
  logic [3:0]  scan1 [1024];

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = 0;
    tot_m = 0;
    drp_m = 0;
  endtask

  // One pulse: valid high for one cycle, low for one; model follows the rules.
  task automatic pulse(input logic [13:0] h);
    @(negedge clk); ev_height = h; ev_valid = 1'b1;
    @(negedge clk); ev_valid = 1'b0;
    if (m_clr) drp_m++;
    else if (acq_en) begin
      if (h < 14'h1900) drp_m++;
      else begin
        model[h[13:4]]++;
        tot_m++;
      end
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic scan();
    rd_addr = 10'd0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      scan0[i] = rd0;
      scan1[i] = rd1;
      rd_addr  = 10'(i + 1);
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while ((busy0 || busy1) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0; ev_valid = 1'b0; ev_height = '0; acq_en = 1'b1;
    clr_req = 1'b0; rd_addr = '0; m_clr = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk++; if (busy0 !== 1'b1) $display("FAIL reset_busy got %b exp 1", busy0); else pass++;
    chk++; if (rd0 !== 24'd0) $display("FAIL reset_rd got %0h exp 0", rd0); else pass++;
    chk++; if (tot0 !== 32'd0) $display("FAIL reset_total got %0d exp 0", tot0); else pass++;
    chk++; if (drp0 !== 16'd0) $display("FAIL reset_drop got %0d exp 0", drp0); else pass++;
    rst_n = 1'b1;
    wait_idle(cyc);
    chk++; if (cyc != 1024) $display("FAIL reset_sweep_len got %0d exp 1024", cyc); else pass++;
    scan();
    for (int i = 0; i < 1024; i++) begin
      chk++; if (scan0[i] !== 24'd0) $display("FAIL reset_ch%0h got %0h exp 0", i, scan0[i]); else pass++;
    end
    chk++; if (tot0 !== 32'd0) $display("FAIL reset_total2 got %0d exp 0", tot0); else pass++;
  endtask

  task automatic test_single();
    rd_addr = 10'h2A0;
    @(negedge clk); ev_height = 14'h2A00; ev_valid = 1'b1;
    @(negedge clk); ev_valid = 1'b0;        // after edge N
    model[10'h2A0]++; tot_m++;
    @(negedge clk);                          // after N+1
    chk++; if (tot0 !== 32'(tot_m - 1)) $display("FAIL single_total_early got %0d exp %0d", tot0, tot_m - 1); else pass++;
    @(negedge clk);                          // after N+2
    chk++; if (tot0 !== 32'(tot_m)) $display("FAIL single_total got %0d exp %0d", tot0, tot_m); else pass++;
    repeat (2) @(negedge clk);               // after N+4
    chk++; if (rd0 !== 24'(model[10'h2A0])) $display("FAIL single_rd got %0d exp %0d", rd0, model[10'h2A0]); else pass++;
  endtask

  task automatic test_forward();
    repeat (100) pulse(14'h2000);
    settle();
    rd_addr = 10'h200;
    repeat (2) @(negedge clk);
    chk++; if (rd0 !== 24'(model[10'h200])) $display("FAIL fwd_ch200 got %0d exp %0d", rd0, model[10'h200]); else pass++;
    chk++; if (rd1 !== 4'(sat4(model[10'h200]))) $display("FAIL fwd_sat got %0d exp %0d", rd1, sat4(model[10'h200])); else pass++;
    chk++; if (tot0 !== 32'(tot_m)) $display("FAIL fwd_total got %0d exp %0d", tot0, tot_m); else pass++;
  endtask

  task automatic test_discrim();
    pulse(14'h18FF);
    chk++; if (drp0 !== 16'(drp_m)) $display("FAIL lld_drop got %0d exp %0d", drp0, drp_m); else pass++;
    pulse(14'h1900);
    acq_en = 1'b0;
    pulse(14'h3000);
    pulse(14'h0100);
    acq_en = 1'b1;
    settle();
    rd_addr = 10'h190;
    repeat (2) @(negedge clk);
    chk++; if (rd0 !== 24'(model[10'h190])) $display("FAIL lld_edge got %0d exp %0d", rd0, model[10'h190]); else pass++;
    rd_addr = 10'h300;
    repeat (2) @(negedge clk);
    chk++; if (rd0 !== 24'(model[10'h300])) $display("FAIL acq_off got %0d exp %0d", rd0, model[10'h300]); else pass++;
    chk++; if (drp0 !== 16'(drp_m)) $display("FAIL discrim_drop got %0d exp %0d", drp0, drp_m); else pass++;
    chk++; if (tot0 !== 32'(tot_m)) $display("FAIL discrim_total got %0d exp %0d", tot0, tot_m); else pass++;
  endtask

  task automatic test_saturate();
    repeat (20) pulse(14'h3F00);
    settle();
    rd_addr = 10'h3F0;
    repeat (2) @(negedge clk);
    chk++; if (rd1 !== 4'd15) $display("FAIL sat_ch got %0d exp 15", rd1); else pass++;
    chk++; if (rd0 !== 24'(model[10'h3F0])) $display("FAIL sat_wide got %0d exp %0d", rd0, model[10'h3F0]); else pass++;
    chk++; if (tot1 !== 32'(tot_m)) $display("FAIL sat_total got %0d exp %0d", tot1, tot_m); else pass++;
  endtask

  task automatic test_random();
    logic [13:0] h;
    logic [13:0] hot [4];
    hot[0] = 14'h2550; hot[1] = 14'h1905; hot[2] = 14'h3FF7; hot[3] = 14'h1234;
    repeat (400) begin
      if ($urandom_range(0, 1) == 0) h = hot[$urandom_range(0, 3)];
      else h = 14'($urandom);
      acq_en = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse(h);
    end
    acq_en = 1'b1;
    settle();
    chk++; if (tot0 !== 32'(tot_m)) $display("FAIL rand_total got %0d exp %0d", tot0, tot_m); else pass++;
    chk++; if (drp0 !== 16'(drp_m)) $display("FAIL rand_drop got %0d exp %0d", drp0, drp_m); else pass++;
    chk++; if (tot1 !== 32'(tot_m)) $display("FAIL rand_total4 got %0d exp %0d", tot1, tot_m); else pass++;
    scan();
    for (int i = 0; i < 1024; i++) begin
      chk++; if (scan0[i] !== 24'(model[i])) $display("FAIL rand_ch%0h got %0d exp %0d", i, scan0[i], model[i]); else pass++;
      chk++; if (scan1[i] !== 4'(sat4(model[i]))) $display("FAIL rand4_ch%0h got %0d exp %0d", i, scan1[i], sat4(model[i])); else pass++;
    end
  endtask

  task automatic test_clear();
    int cyc;
    repeat (5) pulse(14'h2A00);
    settle();
    @(negedge clk); clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    model_clear();
    m_clr = 1'b1;
    chk++; if (busy0 !== 1'b1) $display("FAIL clr_busy got %b exp 1", busy0); else pass++;
    chk++; if (tot0 !== 32'd0) $display("FAIL clr_total got %0d exp 0", tot0); else pass++;
    pulse(14'h2A00);
    wait_idle(cyc);
    m_clr = 1'b0;
    chk++; if (cyc >= 3000) $display("FAIL clr_timeout got %0d cycles exp <3000", cyc); else pass++;
    chk++; if (drp0 !== 16'(drp_m)) $display("FAIL clr_drop got %0d exp %0d", drp0, drp_m); else pass++;
    scan();
    for (int i = 0; i < 1024; i++) begin
      chk++; if (scan0[i] !== 24'd0) $display("FAIL clr_ch%0h got %0h exp 0", i, scan0[i]); else pass++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    repeat (4) pulse(14'h0FF0 + 14'h2000);
    settle();
    // Clear request coincident with an otherwise-valid event: event is dropped.
    @(negedge clk); ev_height = 14'h2000; ev_valid = 1'b1; clr_req = 1'b1;
    @(negedge clk); ev_valid = 1'b0; clr_req = 1'b0;
    model_clear();
    drp_m = 1;
    chk++; if (drp0 !== 16'(drp_m)) $display("FAIL clr_coincident_drop got %0d exp %0d", drp0, drp_m); else pass++;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_clear();
    chk++; if (busy0 !== 1'b1) $display("FAIL mid_rst_busy got %b exp 1", busy0); else pass++;
    chk++; if (drp0 !== 16'd0) $display("FAIL mid_rst_drop got %0d exp 0", drp0); else pass++;
    rst_n = 1'b1;
    wait_idle(cyc);
    chk++; if (cyc != 1024) $display("FAIL mid_rst_sweep_len got %0d exp 1024", cyc); else pass++;
    pulse(14'h2A00);
    settle();
    scan();
    for (int i = 0; i < 1024; i++) begin
      chk++; if (scan0[i] !== 24'(model[i])) $display("FAIL mid_rst_ch%0h got %0d exp %0d", i, scan0[i], model[i]); else pass++;
    end
    chk++; if (tot0 !== 32'(tot_m)) $display("FAIL mid_rst_total got %0d exp %0d", tot0, tot_m); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_forward();
    test_discrim();
    test_saturate();
    test_random();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
